// File: rtl/axi_txn_serializer.sv
// Purpose: serializes cluster AXI traffic toward the Renode bridge, one transaction in flight at a time.
// Latency: one registered grant cycle per transaction; zero-cycle pass-through inside each phase.
// Backpressure: only the granted channel passes valid/ready; every other channel sees valid=0/ready=0.

package renode_memory_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } axi_w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_connection_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_connection_resp_t;

endpackage

module axi_txn_serializer #(
  parameter type         axi_req_t  = renode_memory_pkg::axi_connection_req_t,
  parameter type         axi_resp_t = renode_memory_pkg::axi_connection_resp_t,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_req_t            slv_req_i,
  output axi_resp_t           slv_resp_o,
  output axi_req_t            mst_req_o,
  input  axi_resp_t           mst_resp_i,
  output logic                busy_o,
  output logic [CntWidth-1:0] num_writes_o,
  output logic [CntWidth-1:0] num_reads_o,
  output logic                proto_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } state_e;

  state_e              state_q, state_d;
  logic                prio_q, prio_d;        // 0: write wins next tie, 1: read wins
  logic [7:0]          beat_q, beat_d;
  logic [7:0]          len_q, len_d;
  logic                last_beat;
  logic                wr_done, rd_done, err_set;
  logic [CntWidth-1:0] num_writes_q, num_reads_q;
  logic                proto_err_q;

  // The beat counter is compared against the latched burst length for W.last and R completion.
  assign last_beat = (beat_q == len_q);

  // Next-state and channel routing: only the granted channel is connected, everything else is blocked.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_d     = beat_q;
    len_d      = len_q;
    mst_req_o  = '0;
    slv_resp_o = '0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Round-robin only matters on a tie; a lone request is granted directly.
        if (slv_req_i.aw_valid && slv_req_i.ar_valid) begin
          state_d = prio_q ? ST_AR : ST_AW;
          prio_d  = ~prio_q;
        end else if (slv_req_i.aw_valid) begin
          state_d = ST_AW;
        end else if (slv_req_i.ar_valid) begin
          state_d = ST_AR;
        end
      end

      ST_AW: begin
        mst_req_o.aw        = slv_req_i.aw;
        mst_req_o.aw_valid  = slv_req_i.aw_valid;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready;
        if (slv_req_i.aw_valid && mst_resp_i.aw_ready) begin
          len_d   = slv_req_i.aw.len;
          beat_d  = '0;
          state_d = ST_W;
        end
      end

      ST_W: begin
        // W.last toward memory is regenerated from the AW length; the cluster's flag is only audited.
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w.last   = last_beat;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        slv_resp_o.w_ready = mst_resp_i.w_ready;
        if (slv_req_i.w_valid && mst_resp_i.w_ready) begin
          err_set = (slv_req_i.w.last != last_beat);
          if (last_beat) begin
            state_d = ST_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      ST_B: begin
        slv_resp_o.b       = mst_resp_i.b;
        slv_resp_o.b_valid = mst_resp_i.b_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        if (mst_resp_i.b_valid && slv_req_i.b_ready) begin
          wr_done = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_AR: begin
        mst_req_o.ar        = slv_req_i.ar;
        mst_req_o.ar_valid  = slv_req_i.ar_valid;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready;
        if (slv_req_i.ar_valid && mst_resp_i.ar_ready) begin
          len_d   = slv_req_i.ar.len;
          beat_d  = '0;
          state_d = ST_R;
        end
      end

      ST_R: begin
        // A burst ends on the memory's last flag or on the counted length, whichever comes first.
        slv_resp_o.r       = mst_resp_i.r;
        slv_resp_o.r_valid = mst_resp_i.r_valid;
        mst_req_o.r_ready  = slv_req_i.r_ready;
        if (mst_resp_i.r_valid && slv_req_i.r_ready) begin
          if (mst_resp_i.r.last || last_beat) begin
            rd_done = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Grant state, arbitration priority and burst bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      beat_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

  // Completed-write counter, held at all-ones once full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_writes_q <= '0;
    end else if (wr_done && (num_writes_q != '1)) begin
      num_writes_q <= num_writes_q + CntWidth'(1);
    end
  end

  // Completed-read counter, held at all-ones once full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      num_reads_q <= '0;
    end else if (rd_done && (num_reads_q != '1)) begin
      num_reads_q <= num_reads_q + CntWidth'(1);
    end
  end

  // Sticky W.last disagreement flag; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_q <= 1'b0;
    end else if (err_set) begin
      proto_err_q <= 1'b1;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign num_writes_o = num_writes_q;
  assign num_reads_o  = num_reads_q;
  assign proto_err_o  = proto_err_q;

endmodule

// File: doc/axi_txn_serializer.md
Name: axi_txn_serializer

Overview:
- Sits between the Snitch cluster wide AXI master port and the Renode AXI memory bridge.
- Forces strict one-at-a-time AXI traffic, because the co-simulation bus peripheral services exactly one transaction per exchange.
- Arbitrates AW against AR and regenerates W.last from AW.len.
- Counts completed transactions and flags master-side protocol errors for the testbench.

Parameters:
- axi_req_t, renode_memory_pkg::axi_connection_req_t, AXI request struct type (aw/w/ar payloads, valids, b_ready, r_ready).
- axi_resp_t, renode_memory_pkg::axi_connection_resp_t, AXI response struct type (readies, b/r payloads, valids).
- CntWidth, 32, width of the saturating completion counters.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- slv_req_i  in  axi_req_t  request from cluster wide_out port.
- slv_resp_o  out  axi_resp_t  response to cluster.
- mst_req_o  out  axi_req_t  request to Renode memory.
- mst_resp_i  in  axi_resp_t  response from Renode memory.
- busy_o  out  1  high in any state other than IDLE.
- num_writes_o  out  CntWidth  completed B handshakes, saturating.
- num_reads_o  out  CntWidth  completed R-last handshakes, saturating.
- proto_err_o  out  1  sticky: cluster W.last disagreed with the beat count.

Behaviour:
- Reset, asynchronous on rst_ni low, effective regardless of state or partial burst:
  - State=IDLE, prio=write, beat counter=0, len register=0.
  - Counters=0, proto_err_o=0, busy_o=0.
  - All mst_req_o valids=0, b_ready=0, r_ready=0.
  - All slv_resp_o readies=0, b_valid=0, r_valid=0.
  - Payload fields are don't-care; the bench checks only valid/ready.
  - No transaction survives reset.
- States: IDLE, AW, W, B, AR, R.
- IDLE:
  - All channels blocked: valids/readies toward both sides = 0.
  - slv aw_valid only -> AW. slv ar_valid only -> AR.
  - Both valid -> go to the channel selected by prio, then toggle prio (round-robin).
  - Grant is registered, so the first forwarded valid appears one cycle after the request is seen in IDLE.
- AW:
  - Combinational pass-through: mst.aw = slv.aw, mst.aw_valid = slv.aw_valid, slv.aw_ready = mst.aw_ready.
  - On handshake: latch aw.len, clear the beat counter, go to W.
- W:
  - Pass-through of w payload, valid and ready.
  - mst.w.last is driven as (beat == len), never taken from the cluster.
  - Each handshake increments beat.
  - If slv.w.last != (beat == len) on a handshake, set proto_err_o (sticky until reset).
  - Handshake with beat == len -> B.
- B:
  - Pass-through of b payload and valid; mst b_ready = slv b_ready.
  - On handshake: num_writes_o += 1, saturating at all-ones; go to IDLE.
- AR: pass-through as AW. On handshake, latch ar.len and go to R.
- R:
  - Pass-through of r payload, valid and ready. Beats are counted.
  - The handshake carrying mst r.last (or beat == len) -> num_reads_o += 1 saturating, go to IDLE.
- Blocked channels:
  - W data presented before AW is granted sees w_ready = 0. This is legal AXI because the master must not depend on w_ready.
  - AR presented during a write is held off until the write's B completes, and vice versa.
- Outstanding limit: exactly one transaction. Pass-through adds zero cycles inside a phase; each transaction costs 1 idle/grant cycle.
- Back-to-back bursts: the earliest next grant is the cycle after B/R-last (IDLE lasts 1 cycle).
- Wrap-around: the counter holds at 2^CntWidth-1. len is 8 bits, so a burst of 256 beats is supported; beat never wraps within a burst.
- Simultaneous events: at a given edge, only the handshake of the currently granted channel has effect.

Test Plan:
- Single write: AW len=3 addr 0x8000_0000, 4 W beats with last on beat 4 -> exactly 4 mst W handshakes; mst w.last only on beat 4; B OKAY forwarded; num_writes_o=1; busy_o back to 0 one cycle after B.
- Single read: AR len=7 -> 8 R beats forwarded unchanged; num_reads_o=1; AR accepted 1 cycle after ar_valid rises in IDLE.
- Contention: aw_valid and ar_valid raised together twice in sequence -> write first, read second, then read first, write second (round-robin); never two outstanding.
- W before AW: cluster asserts w_valid 3 cycles before aw_valid -> w_ready=0 until the AW handshake completes; data is not lost.
- Protocol error: AW len=3, cluster asserts w.last on beat 2 -> proto_err_o=1 and stays 1; mst w.last still only on beat 4.
- Reset mid-burst: rst_ni low after beat 2 of a 4-beat write -> same cycle, all valids/readies=0, counters=0, busy_o=0; after release, a new read completes normally.
